// File: rtl/shifter_univ_if.sv
// shifter_univ_if: handshake and data bundle for the universal shift register.
//   master: drives mode, shift_right, shift_left, d, amount, start;
//           observes q, ser_out_r, ser_out_l, busy, done.
//   slave : the shift register side (directions reversed).
interface shifter_univ_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned AW = $clog2(WIDTH) + 1;

  logic [2:0]       mode;
  logic             shift_right;
  logic             shift_left;
  logic [WIDTH-1:0] d;
  logic [AW-1:0]    amount;
  logic             start;
  logic [WIDTH-1:0] q;
  logic             ser_out_r;
  logic             ser_out_l;
  logic             busy;
  logic             done;

  modport master (
    output mode, shift_right, shift_left, d, amount, start,
    input  q, ser_out_r, ser_out_l, busy, done
  );

  modport slave (
    input  mode, shift_right, shift_left, d, amount, start,
    output q, ser_out_r, ser_out_l, busy, done
  );
endinterface

// File: rtl/shifter_univ.sv
// shifter_univ: parametrised universal shift register with a multi-position
// shift sequencer (one single-bit shift per clock) under start/busy/done.
//   clk : clock, all state updates on the rising edge
//   clr : synchronous reset, active-low; aborts any operation in progress
//   bus : shifter_univ_if slave port
//         mode/amount/d sampled only with an accepted start (IDLE only)
//         shift_right/shift_left serial fill bits, sampled live on each shift
//         q register, ser_out_r = q[0], ser_out_l = q[WIDTH-1]
//         busy high in RUN, done high for the one cycle in DONE
module shifter_univ #(
  parameter int unsigned WIDTH = 8
) (
  input logic                 clk,
  input logic                 clr,
  shifter_univ_if.slave       bus
);

  localparam int unsigned AW = $clog2(WIDTH) + 1;

  localparam logic [2:0] ModeHold = 3'b000;
  localparam logic [2:0] ModeShr  = 3'b001;
  localparam logic [2:0] ModeShl  = 3'b010;
  localparam logic [2:0] ModeLoad = 3'b011;
  localparam logic [2:0] ModeRor  = 3'b100;
  localparam logic [2:0] ModeRol  = 3'b101;
  localparam logic [2:0] ModeSar  = 3'b110;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;

  // One single-bit step of the selected operation; hold/load/reserved keep v.
  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v,
                                                 input logic [2:0]       m,
                                                 input logic             sr,
                                                 input logic             sl);
    logic [WIDTH-1:0] r;
    r = v;
    case (m)
      ModeShr: r = {sr, v[WIDTH-1:1]};
      ModeShl: r = {v[WIDTH-2:0], sl};
      ModeRor: r = {v[0], v[WIDTH-1:1]};
      ModeRol: r = {v[WIDTH-2:0], v[WIDTH-1]};
      ModeSar: r = {v[WIDTH-1], v[WIDTH-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  function automatic logic is_shift(input logic [2:0] m);
    return (m == ModeShr) || (m == ModeShl) || (m == ModeRor) ||
           (m == ModeRol) || (m == ModeSar);
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= StIdle;
      q_q     <= '0;
      cnt_q   <= '0;
      mode_q  <= ModeHold;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.mode == ModeLoad) begin
            q_d     = bus.d;
            state_d = StDone;
          end else if (is_shift(bus.mode) && (bus.amount != '0)) begin
            mode_d  = bus.mode;
            cnt_d   = bus.amount;
            state_d = StRun;
          end else begin
            // Hold, reserved, or a zero-length shift completes immediately.
            state_d = StDone;
          end
        end
      end
      StRun: begin
        q_d   = shift_one(q_q, mode_q, bus.shift_right, bus.shift_left);
        cnt_d = cnt_q - AW'(1);
        if (cnt_q == AW'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        // Start is not accepted here; the requester waits for IDLE.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs
  always_comb begin
    bus.q         = q_q;
    bus.ser_out_r = q_q[0];
    bus.ser_out_l = q_q[WIDTH-1];
    bus.busy      = (state_q == StRun);
    bus.done      = (state_q == StDone);
  end

endmodule

// File: tb/tb_shifter_univ.sv
// tb_shifter_univ: table-driven self-checking bench for shifter_univ with a
// scoreboard queue of expected results (pushed at start, popped at done).
module tb_shifter_univ;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned AW    = $clog2(WIDTH) + 1;

  logic clk = 1'b0;
  logic clr;

  shifter_univ_if #(.WIDTH(WIDTH)) bus ();

  shifter_univ #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] init;
    logic [2:0]       mode;
    logic [AW-1:0]    amount;
    logic             sr;
    logic             sl;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] exp_q;
    int               exp_busy;
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] exp_fifo[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Drive a start pulse for one edge; returns at the negedge after accept edge.
  task automatic start_op(input logic [2:0] m, input logic [AW-1:0] amt,
                          input logic sr, input logic sl, input logic [WIDTH-1:0] dv);
    @(negedge clk);
    bus.mode        = m;
    bus.amount      = amt;
    bus.shift_right = sr;
    bus.shift_left  = sl;
    bus.d           = dv;
    bus.start       = 1'b1;
    @(negedge clk);
    bus.start       = 1'b0;
  endtask

  // Count remaining busy cycles, then expect a single done cycle with the
  // scoreboard's result, then idle.
  task automatic finish_op(input string name, input int exp_busy);
    int n;
    logic [WIDTH-1:0] e;
    n = 0;
    while (bus.busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check({name, " busy cycles"}, n, exp_busy);
    check({name, " done"}, {31'd0, bus.done}, 32'd1);
    if (exp_fifo.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s scoreboard: got empty want entry", name);
    end else begin
      e = exp_fifo.pop_front();
      check({name, " q"}, {24'd0, bus.q}, {24'd0, e});
      check({name, " serouts"}, {30'd0, bus.ser_out_l, bus.ser_out_r},
            {30'd0, e[WIDTH-1], e[0]});
    end
    @(negedge clk);
    check({name, " idle after done"}, {30'd0, bus.busy, bus.done}, 32'd0);
  endtask

  task automatic do_op(input string name, input logic [2:0] m, input logic [AW-1:0] amt,
                       input logic sr, input logic sl, input logic [WIDTH-1:0] dv,
                       input logic [WIDTH-1:0] expq, input int exp_busy);
    exp_fifo.push_back(expq);
    start_op(m, amt, sr, sl, dv);
    finish_op(name, exp_busy);
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    do_op("load", 3'b011, '0, 1'b0, 1'b0, v, v, 0);
  endtask

  vec_t vecs[13];
  logic [WIDTH-1:0] seq[3];

  initial begin
    vecs[0]  = '{"shr3",      8'hA5, 3'b001, 4'd3,  1'b1, 1'b0, 8'h00, 8'hF4, 3};
    vecs[1]  = '{"shl2",      8'hA5, 3'b010, 4'd2,  1'b0, 1'b0, 8'h00, 8'h94, 2};
    vecs[2]  = '{"rol1",      8'h81, 3'b101, 4'd1,  1'b0, 1'b0, 8'h00, 8'h03, 1};
    vecs[3]  = '{"rol8",      8'hA5, 3'b101, 4'd8,  1'b0, 1'b0, 8'h00, 8'hA5, 8};
    vecs[4]  = '{"sar2",      8'h90, 3'b110, 4'd2,  1'b0, 1'b0, 8'h00, 8'hE4, 2};
    vecs[5]  = '{"sar9",      8'h40, 3'b110, 4'd9,  1'b1, 1'b1, 8'h00, 8'h00, 9};
    vecs[6]  = '{"ror3",      8'hA5, 3'b100, 4'd3,  1'b0, 1'b0, 8'h00, 8'hB4, 3};
    vecs[7]  = '{"shr0",      8'hA5, 3'b001, 4'd0,  1'b1, 1'b1, 8'h00, 8'hA5, 0};
    vecs[8]  = '{"reserved",  8'hA5, 3'b111, 4'd5,  1'b1, 1'b1, 8'h00, 8'hA5, 0};
    vecs[9]  = '{"hold",      8'h5A, 3'b000, 4'd4,  1'b1, 1'b1, 8'h00, 8'h5A, 0};
    vecs[10] = '{"shl15fill", 8'h3C, 3'b010, 4'd15, 1'b0, 1'b1, 8'h00, 8'hFF, 15};
    vecs[11] = '{"shr10zero", 8'h3C, 3'b001, 4'd10, 1'b0, 1'b1, 8'h00, 8'h00, 10};
    vecs[12] = '{"loadamt",   8'h00, 3'b011, 4'd7,  1'b1, 1'b1, 8'hC3, 8'hC3, 0};

    bus.mode        = 3'b000;
    bus.amount      = '0;
    bus.shift_right = 1'b0;
    bus.shift_left  = 1'b0;
    bus.d           = '0;
    bus.start       = 1'b0;
    clr             = 1'b0;
    repeat (2) @(negedge clk);
    check("reset q", {24'd0, bus.q}, 32'd0);
    check("reset busy/done", {30'd0, bus.busy, bus.done}, 32'd0);
    clr = 1'b1;

    // Table-driven operations, each preceded by a load of the start value.
    for (int i = 0; i < 13; i++) begin
      load(vecs[i].init);
      do_op(vecs[i].name, vecs[i].mode, vecs[i].amount, vecs[i].sr, vecs[i].sl,
            vecs[i].d, vecs[i].exp_q, vecs[i].exp_busy);
    end

    // Per-edge trace of a right shift with fill 1 and ser_out_r tracking.
    seq[0] = 8'hD2;
    seq[1] = 8'hE9;
    seq[2] = 8'hF4;
    load(8'hA5);
    exp_fifo.push_back(8'hF4);
    start_op(3'b001, 4'd3, 1'b1, 1'b0, 8'h00);
    check("trace q before first shift", {24'd0, bus.q}, 32'hA5);
    for (int i = 0; i < 3; i++) begin
      check("trace busy", {31'd0, bus.busy}, 32'd1);
      @(negedge clk);
      check("trace q", {24'd0, bus.q}, {24'd0, seq[i]});
      check("trace ser_out_r", {31'd0, bus.ser_out_r}, {31'd0, seq[i][0]});
    end
    finish_op("trace", 0);

    // Start while busy with different mode/amount must be ignored.
    load(8'hA5);
    exp_fifo.push_back(8'hF4);
    start_op(3'b001, 4'd3, 1'b1, 1'b0, 8'h00);
    bus.mode   = 3'b010;
    bus.amount = 4'd1;
    bus.d      = 8'h11;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    finish_op("start ignored in run", 2);

    // Reset mid-operation aborts with no done pulse.
    load(8'hA5);
    start_op(3'b001, 4'd4, 1'b0, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    check("abort partial q", {24'd0, bus.q}, 32'h29);
    clr = 1'b0;
    @(negedge clk);
    check("abort q", {24'd0, bus.q}, 32'd0);
    check("abort busy/done", {30'd0, bus.busy, bus.done}, 32'd0);
    clr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort no done", {30'd0, bus.busy, bus.done}, 32'd0);
    end
    check("scoreboard drained", exp_fifo.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
